// File: rtl/rc_sched_pkg.sv
// ---------------------------------------------------------------------------
// rc_sched_pkg
//   Shared types and widths for the RC high-pass channel scheduler.
//   Contents:
//     rc_state_e  - scheduler FSM states
//     COEF_W      - coefficient width (unsigned Q0.16)
//     SAMPLE_W    - audio sample width (signed)
//     SUM_W       - width of the shifted products and of the difference sum
//     PROD_W      - width of the signed multiplier results
//     sat16()     - clamp a SUM_W value into the signed 16-bit range
// ---------------------------------------------------------------------------
package rc_sched_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LATCH     = 3'd1,
      LEAK_MUL  = 3'd2,
      ALPHA_MUL = 3'd3,
      WRITE     = 3'd4
   } rc_state_e;

   localparam int COEF_W   = 16;
   localparam int SAMPLE_W = 16;
   localparam int SUM_W    = 18;
   localparam int PROD_W   = 34;

   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SUM_W-1:0] v);
      logic signed [SAMPLE_W-1:0] r;
      if (v > 18'sd32767) begin
         r = 16'sh7FFF;
      end else if (v < -18'sd32768) begin
         r = 16'sh8000;
      end else begin
         r = v[SAMPLE_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/rc_step_datapath.sv
// ---------------------------------------------------------------------------
// rc_step_datapath
//   Registered two-multiply leaky high-pass step, one stage per enable:
//     leak_en : t <= (leak * y_prev) >>> 16
//     alpha_en: y <= (alpha * (t + x - x_prev)) >>> 16
//   Coefficients are unsigned Q0.16 and are zero-extended before the
//   signed multiplies. Shifts are arithmetic (floor toward -inf).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   leak_en         load the leak-product stage
//   alpha_en        load the alpha-product stage
//   leak, alpha     coefficients for the channel being processed
//   y_prev          previous output of that channel
//   x, x_prev       current and previous input of that channel
//   y               step result, SUM_W bits (narrowed by the caller)
// ---------------------------------------------------------------------------
module rc_step_datapath
   import rc_sched_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       leak_en,
   input  logic                       alpha_en,
   input  logic [COEF_W-1:0]          leak,
   input  logic [COEF_W-1:0]          alpha,
   input  logic signed [SAMPLE_W-1:0] y_prev,
   input  logic signed [SAMPLE_W-1:0] x,
   input  logic signed [SAMPLE_W-1:0] x_prev,
   output logic signed [SUM_W-1:0]    y
);

   logic signed [PROD_W-1:0] leak_ext, alpha_ext, y_prev_ext, s_ext;
   logic signed [PROD_W-1:0] p1, p2;
   logic signed [SUM_W-1:0]  x_ext, x_prev_ext, s;
   logic signed [SUM_W-1:0]  t_d, t_q, y_d, y_q;

   always_comb begin
      leak_ext   = {{(PROD_W-COEF_W){1'b0}}, leak};
      alpha_ext  = {{(PROD_W-COEF_W){1'b0}}, alpha};
      y_prev_ext = {{(PROD_W-SAMPLE_W){y_prev[SAMPLE_W-1]}}, y_prev};
      p1         = leak_ext * y_prev_ext;

      // |t| <= 32768 and |x - x_prev| <= 65535, so the sum fits SUM_W.
      x_ext      = {{(SUM_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
      x_prev_ext = {{(SUM_W-SAMPLE_W){x_prev[SAMPLE_W-1]}}, x_prev};
      s          = t_q + x_ext - x_prev_ext;
      s_ext      = {{(PROD_W-SUM_W){s[SUM_W-1]}}, s};
      p2         = alpha_ext * s_ext;

      t_d = t_q;
      y_d = y_q;
      if (leak_en) begin
         t_d = SUM_W'(p1 >>> 16);
      end
      if (alpha_en) begin
         y_d = SUM_W'(p2 >>> 16);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         t_q <= '0;
         y_q <= '0;
      end else begin
         t_q <= t_d;
         y_q <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/rc_filter_channel_scheduler.sv
// ---------------------------------------------------------------------------
// rc_filter_channel_scheduler
//   Shares one leaky RC high-pass step datapath across NUM_CH channels.
//   Each audio_clk_en frame: latch all inputs and snapshot coefficients,
//   walk channels through LEAK_MUL -> ALPHA_MUL -> WRITE, then present all
//   outputs at once with a one-cycle out_valid.
//   Build option: define RC_SCHED_SATURATION_EN to clamp each result to the
//   signed 16-bit range; otherwise results wrap (low 16 bits kept).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   audio_clk_en   one-cycle frame strobe
//   in             NUM_CH signed 16-bit samples, channel k at [16k+15:16k]
//   out            NUM_CH filtered samples, same packing, held between frames
//   out_valid      one-cycle pulse when out updates
//   busy           high from LATCH through the last WRITE
//   overrun        one-cycle pulse (cycle after) for a strobe seen while busy
//   cfg_we/cfg_sel/cfg_ch/cfg_data  coefficient write (sel 0 = alpha, 1 = leak)
//   dbg_state      current FSM state
// Handshake: audio_clk_en is a fire-and-forget strobe, accepted only in IDLE;
//   out_valid is a one-cycle qualifier with no back-pressure.
// ---------------------------------------------------------------------------
module rc_filter_channel_scheduler
   import rc_sched_pkg::*;
#(
   parameter int          NUM_CH        = 4,
   parameter logic [15:0] ALPHA_DEFAULT = 16'hF000,
   parameter logic [15:0] LEAK_DEFAULT  = 16'hFFF0
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            audio_clk_en,
   input  logic [SAMPLE_W*NUM_CH-1:0]                      in,
   output logic [SAMPLE_W*NUM_CH-1:0]                      out,
   output logic                                            out_valid,
   output logic                                            busy,
   output logic                                            overrun,
   input  logic                                            cfg_we,
   input  logic                                            cfg_sel,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
   input  logic [COEF_W-1:0]                               cfg_data,
   output logic [2:0]                                      dbg_state
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   rc_state_e state_d, state_q;
   logic [CH_W-1:0] ch_d, ch_q;
   logic [SAMPLE_W*NUM_CH-1:0] out_d, out_q;
   logic out_valid_d, out_valid_q;
   logic overrun_d, overrun_q;

   // Live coefficients (written by cfg) and per-frame shadows used by the datapath.
   logic [COEF_W-1:0] alpha_d[NUM_CH], alpha_q[NUM_CH];
   logic [COEF_W-1:0] leak_d[NUM_CH], leak_q[NUM_CH];
   logic [COEF_W-1:0] alpha_sh_d[NUM_CH], alpha_sh_q[NUM_CH];
   logic [COEF_W-1:0] leak_sh_d[NUM_CH], leak_sh_q[NUM_CH];

   logic signed [SAMPLE_W-1:0] x_lat_d[NUM_CH], x_lat_q[NUM_CH];
   logic signed [SAMPLE_W-1:0] x_prev_d[NUM_CH], x_prev_q[NUM_CH];
   logic signed [SAMPLE_W-1:0] y_prev_d[NUM_CH], y_prev_q[NUM_CH];

   logic busy_w;
   logic signed [SUM_W-1:0]    y_dp;
   logic signed [SAMPLE_W-1:0] y_narrow;

   assign busy_w = (state_q != IDLE);

   rc_step_datapath u_step (
      .clk      (clk),
      .reset    (reset),
      .leak_en  (state_q == LEAK_MUL),
      .alpha_en (state_q == ALPHA_MUL),
      .leak     (leak_sh_q[ch_q]),
      .alpha    (alpha_sh_q[ch_q]),
      .y_prev   (y_prev_q[ch_q]),
      .x        (x_lat_q[ch_q]),
      .x_prev   (x_prev_q[ch_q]),
      .y        (y_dp)
   );

`ifdef RC_SCHED_SATURATION_EN
   assign y_narrow = sat16(y_dp);
`else
   assign y_narrow = SAMPLE_W'(y_dp);
`endif

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      overrun_d   = audio_clk_en && busy_w;
      alpha_d     = alpha_q;
      leak_d      = leak_q;
      alpha_sh_d  = alpha_sh_q;
      leak_sh_d   = leak_sh_q;
      x_lat_d     = x_lat_q;
      x_prev_d    = x_prev_q;
      y_prev_d    = y_prev_q;

      // Live registers only; the LATCH snapshot below reads the _q copies,
      // so a write coinciding with LATCH lands in the following frame.
      if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
         if (cfg_sel) begin
            leak_d[cfg_ch] = cfg_data;
         end else begin
            alpha_d[cfg_ch] = cfg_data;
         end
      end

      case (state_q)
         IDLE: begin
            if (audio_clk_en) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            for (int k = 0; k < NUM_CH; k++) begin
               x_lat_d[k] = in[SAMPLE_W*k +: SAMPLE_W];
            end
            alpha_sh_d = alpha_q;
            leak_sh_d  = leak_q;
            ch_d       = '0;
            state_d    = LEAK_MUL;
         end
         LEAK_MUL: begin
            state_d = ALPHA_MUL;
         end
         ALPHA_MUL: begin
            state_d = WRITE;
         end
         WRITE: begin
            y_prev_d[ch_q] = y_narrow;
            x_prev_d[ch_q] = x_lat_q[ch_q];
            if (ch_q == CH_W'(NUM_CH - 1)) begin
               // Publish all channels together, including the one just written.
               for (int k = 0; k < NUM_CH; k++) begin
                  out_d[SAMPLE_W*k +: SAMPLE_W] = y_prev_d[k];
               end
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               ch_d    = ch_q + CH_W'(1);
               state_d = LEAK_MUL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            alpha_q[k]    <= ALPHA_DEFAULT;
            leak_q[k]     <= LEAK_DEFAULT;
            alpha_sh_q[k] <= ALPHA_DEFAULT;
            leak_sh_q[k]  <= LEAK_DEFAULT;
            x_lat_q[k]    <= '0;
            x_prev_q[k]   <= '0;
            y_prev_q[k]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         alpha_q     <= alpha_d;
         leak_q      <= leak_d;
         alpha_sh_q  <= alpha_sh_d;
         leak_sh_q   <= leak_sh_d;
         x_lat_q     <= x_lat_d;
         x_prev_q    <= x_prev_d;
         y_prev_q    <= y_prev_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_w;
   assign overrun   = overrun_q;
   assign dbg_state = state_q;

endmodule
